// File: rtl/fc_tile_sequencer.sv
// fc_tile_sequencer: control sequencer for the fully-connected engine.
// Loads an IFM vector over a valid/ready stream, then sweeps the stored vector once
// per output tile, driving buffer reads, accumulate/clear, optional bias and a
// per-tile output strobe. Sizes are runtime inputs bounded by the parameters.
module fc_tile_sequencer #(
  parameter int IFM_MAX  = 9162,
  parameter int TILE_MAX = 512,
  parameter int RD_LAT   = 2,
  localparam int AW = $clog2(IFM_MAX + 1),
  localparam int TW = $clog2(TILE_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] cfg_ifm_len,
  input  logic [TW-1:0] cfg_num_tiles,
  input  logic          cfg_bias_en,
  input  logic          ifm_valid,
  output logic          ifm_ready,
  output logic          ifm_wr_en,
  output logic [AW-1:0] ifm_wr_addr,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          acc_en,
  output logic          acc_clr,
  output logic          bias_en,
  output logic          out_valid,
  output logic [TW-1:0] out_tile_idx,
  output logic          busy,
  output logic          done,
  output logic          err_cfg
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_BIAS    = 3'd4;
  localparam logic [2:0] S_EMIT    = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(RD_LAT - 1);

  logic [2:0]        state;
  logic [AW-1:0]     len_last;
  logic [TW-1:0]     tiles_last;
  logic              bias_cfg;
  logic [TW-1:0]     tile_cnt;
  logic [DW-1:0]     drain_cnt;
  logic [RD_LAT-1:0] acc_pipe;
  logic              cfg_ok;

  assign cfg_ok = (cfg_ifm_len != '0) && (cfg_ifm_len <= AW'(IFM_MAX)) &&
                  (cfg_num_tiles != '0) && (cfg_num_tiles <= TW'(TILE_MAX));

  // Write strobe qualifies the registered ready with the live beat so the buffer
  // captures data in the same cycle it is presented.
  assign ifm_wr_en = ifm_valid & ifm_ready;
  assign acc_en    = acc_pipe[RD_LAT-1];

  // Read-latency matching: acc_en follows rd_en by RD_LAT cycles; abort flushes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_pipe <= '0;
    end else if (abort && state != S_IDLE) begin
      acc_pipe <= '0;
    end else begin
      acc_pipe <= RD_LAT'({acc_pipe, rd_en});
    end
  end

  // Main sequencer: state, counters and all registered control strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      len_last     <= '0;
      tiles_last   <= '0;
      bias_cfg     <= 1'b0;
      tile_cnt     <= '0;
      drain_cnt    <= '0;
      ifm_ready    <= 1'b0;
      ifm_wr_addr  <= '0;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      acc_clr      <= 1'b0;
      bias_en      <= 1'b0;
      out_valid    <= 1'b0;
      out_tile_idx <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_cfg      <= 1'b0;
    end else begin
      err_cfg   <= 1'b0;
      acc_clr   <= 1'b0;
      bias_en   <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      if (abort && state != S_IDLE) begin
        state     <= S_IDLE;
        ifm_ready <= 1'b0;
        rd_en     <= 1'b0;
        busy      <= 1'b0;
        acc_clr   <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (cfg_ok) begin
                state       <= S_LOAD;
                busy        <= 1'b1;
                ifm_ready   <= 1'b1;
                ifm_wr_addr <= '0;
                len_last    <= cfg_ifm_len - AW'(1);
                tiles_last  <= cfg_num_tiles - TW'(1);
                bias_cfg    <= cfg_bias_en;
                tile_cnt    <= '0;
              end else begin
                err_cfg <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            if (ifm_wr_en) begin
              if (ifm_wr_addr == len_last) begin
                state     <= S_COMPUTE;
                ifm_ready <= 1'b0;
                rd_en     <= 1'b1;
                rd_addr   <= '0;
              end else begin
                ifm_wr_addr <= ifm_wr_addr + AW'(1);
              end
            end
          end
          S_COMPUTE: begin
            if (rd_addr == len_last) begin
              state     <= S_DRAIN;
              rd_en     <= 1'b0;
              drain_cnt <= '0;
            end else begin
              rd_addr <= rd_addr + AW'(1);
            end
          end
          S_DRAIN: begin
            if (drain_cnt == DRAIN_LAST) begin
              if (bias_cfg) begin
                state   <= S_BIAS;
                bias_en <= 1'b1;
              end else begin
                state        <= S_EMIT;
                out_valid    <= 1'b1;
                acc_clr      <= 1'b1;
                out_tile_idx <= tile_cnt;
              end
            end else begin
              drain_cnt <= drain_cnt + DW'(1);
            end
          end
          S_BIAS: begin
            state        <= S_EMIT;
            out_valid    <= 1'b1;
            acc_clr      <= 1'b1;
            out_tile_idx <= tile_cnt;
          end
          S_EMIT: begin
            if (tile_cnt == tiles_last) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state    <= S_COMPUTE;
              tile_cnt <= tile_cnt + TW'(1);
              rd_en    <= 1'b1;
              rd_addr  <= '0;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            ifm_ready <= 1'b0;
            rd_en     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fc_tile_sequencer.sv
// Self-checking bench for fc_tile_sequencer: config-check table, directed jobs,
// randomized jobs against a timeline model, and mid-operation reset.
module tb_fc_tile_sequencer;

  localparam int IFM_MAX  = 9162;
  localparam int TILE_MAX = 512;
  localparam int RD_LAT   = 2;
  localparam int AW = $clog2(IFM_MAX + 1);
  localparam int TW = $clog2(TILE_MAX + 1);
  localparam int MAXC = 20000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] cfg_ifm_len = '0;
  logic [TW-1:0] cfg_num_tiles = '0;
  logic          cfg_bias_en = 1'b0;
  logic          ifm_valid = 1'b0;
  logic          ifm_ready, ifm_wr_en, rd_en, acc_en, acc_clr, bias_en;
  logic          out_valid, busy, done, err_cfg;
  logic [AW-1:0] ifm_wr_addr, rd_addr;
  logic [TW-1:0] out_tile_idx;

  fc_tile_sequencer #(.IFM_MAX(IFM_MAX), .TILE_MAX(TILE_MAX), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_ifm_len(cfg_ifm_len), .cfg_num_tiles(cfg_num_tiles), .cfg_bias_en(cfg_bias_en),
    .ifm_valid(ifm_valid), .ifm_ready(ifm_ready), .ifm_wr_en(ifm_wr_en),
    .ifm_wr_addr(ifm_wr_addr), .rd_en(rd_en), .rd_addr(rd_addr), .acc_en(acc_en),
    .acc_clr(acc_clr), .bias_en(bias_en), .out_valid(out_valid),
    .out_tile_idx(out_tile_idx), .busy(busy), .done(done), .err_cfg(err_cfg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          acc_en;
    logic          acc_clr;
    logic          bias_en;
    logic          out_valid;
    logic [TW-1:0] idx;
    logic          busy;
    logic          done;
    logic          err;
  } obs_t;

  typedef struct {
    int len;
    int tiles;
    bit ab;
    bit exp_err;
    bit exp_busy;
  } vec_t;

  int   passed = 0;
  int   total  = 0;
  obs_t exp_a [MAXC];
  bit   vv [MAXC];
  int   ov_q[$];
  int   done_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Address/index fields are only meaningful alongside their strobes.
  function automatic obs_t sample();
    obs_t o;
    o.ready     = ifm_ready;
    o.wr_en     = ifm_wr_en;
    o.wr_addr   = ifm_wr_en ? ifm_wr_addr : '0;
    o.rd_en     = rd_en;
    o.rd_addr   = rd_en ? rd_addr : '0;
    o.acc_en    = acc_en;
    o.acc_clr   = acc_clr;
    o.bias_en   = bias_en;
    o.out_valid = out_valid;
    o.idx       = out_valid ? out_tile_idx : '0;
    o.busy      = busy;
    o.done      = done;
    o.err       = err_cfg;
    return o;
  endfunction

  function automatic logic [63:0] raw_outs();
    return 64'({ifm_ready, ifm_wr_en, ifm_wr_addr, rd_en, rd_addr, acc_en, acc_clr,
                bias_en, out_valid, out_tile_idx, busy, done, err_cfg});
  endfunction

  // Timeline model: interval 0 is the cycle after start is sampled. Writes follow the
  // accepted beats; tile j computes from c0 + j*P with P = len + RD_LAT + bias + 1.
  // abort_at/restart_at: -1 none, -2 random within the busy window.
  task automatic run_job(input string name, input int len, input int tiles, input bit bias,
                         input int vmode, input int abort_at, input int restart_at);
    int p, c0, d, n, nacc, lend, cj, hi;
    p = len + RD_LAT + int'(bias) + 1;
    for (int k = 0; k < MAXC; k++) begin
      exp_a[k] = '0;
      case (vmode)
        0:       vv[k] = 1'b1;
        1:       vv[k] = (k % 2 == 0);
        default: vv[k] = 1'($urandom_range(0, 1));
      endcase
    end
    nacc = 0;
    lend = 0;
    for (int k = 0; nacc < len; k++) begin
      exp_a[k].ready = 1'b1;
      if (vv[k]) begin
        exp_a[k].wr_en   = 1'b1;
        exp_a[k].wr_addr = AW'(nacc);
        nacc++;
        if (nacc == len) lend = k;
      end
    end
    c0 = lend + 1;
    d  = c0 + tiles * p;
    for (int j = 0; j < tiles; j++) begin
      cj = c0 + j * p;
      for (int i = 0; i < len; i++) begin
        exp_a[cj + i].rd_en          = 1'b1;
        exp_a[cj + i].rd_addr        = AW'(i);
        exp_a[cj + RD_LAT + i].acc_en = 1'b1;
      end
      if (bias) exp_a[cj + len + RD_LAT].bias_en = 1'b1;
      exp_a[cj + p - 1].out_valid = 1'b1;
      exp_a[cj + p - 1].acc_clr   = 1'b1;
      exp_a[cj + p - 1].idx       = TW'(j);
    end
    exp_a[d].done = 1'b1;
    for (int k = 0; k <= d; k++) exp_a[k].busy = 1'b1;
    n = d + 2;
    if (abort_at == -2) abort_at = $urandom_range(0, d);
    if (abort_at >= 0) begin
      for (int k = abort_at + 1; k < MAXC; k++) exp_a[k] = '0;
      exp_a[abort_at + 1].acc_clr = 1'b1;
      n = abort_at + 3;
    end
    hi = (abort_at >= 0) ? abort_at : d;
    if (restart_at == -2) restart_at = $urandom_range(0, hi);

    ov_q.delete();
    done_cnt = 0;
    cfg_ifm_len   = AW'(len);
    cfg_num_tiles = TW'(tiles);
    cfg_bias_en   = bias;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_ifm_len   = AW'($urandom_range(0, 2 * IFM_MAX));
    cfg_num_tiles = TW'($urandom_range(0, 1023));
    cfg_bias_en   = 1'($urandom_range(0, 1));
    for (int k = 0; k < n; k++) begin
      ifm_valid = vv[k];
      abort     = (k == abort_at);
      start     = (k == restart_at);
      if (start) begin
        cfg_ifm_len   = AW'($urandom_range(0, 20));
        cfg_num_tiles = TW'($urandom_range(0, 3));
      end
      @(negedge clk);
      chk($sformatf("%s c%0d", name, k), 64'(sample()), 64'(exp_a[k]));
      if (out_valid) ov_q.push_back(k);
      if (done) done_cnt++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    abort = 1'b0;
    ifm_valid = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt [6];
    int per;
    vt[0] = '{len: 0,           tiles: 2,            ab: 1'b0, exp_err: 1'b1, exp_busy: 1'b0};
    vt[1] = '{len: 4,           tiles: TILE_MAX + 1, ab: 1'b0, exp_err: 1'b1, exp_busy: 1'b0};
    vt[2] = '{len: IFM_MAX + 1, tiles: 1,            ab: 1'b0, exp_err: 1'b1, exp_busy: 1'b0};
    vt[3] = '{len: 5,           tiles: 0,            ab: 1'b0, exp_err: 1'b1, exp_busy: 1'b0};
    vt[4] = '{len: IFM_MAX,     tiles: TILE_MAX,     ab: 1'b0, exp_err: 1'b0, exp_busy: 1'b1};
    vt[5] = '{len: 1,           tiles: 1,            ab: 1'b1, exp_err: 1'b0, exp_busy: 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset state", raw_outs(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Config checking; abort alongside start in IDLE must not block the launch.
    for (int i = 0; i < 6; i++) begin
      cfg_ifm_len   = AW'(vt[i].len);
      cfg_num_tiles = TW'(vt[i].tiles);
      abort = vt[i].ab;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d err_cfg", i), 64'(err_cfg), 64'(vt[i].exp_err));
      chk($sformatf("vec%0d busy", i), 64'(busy), 64'(vt[i].exp_busy));
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("vec%0d err_cfg pulse end", i), 64'(err_cfg), 64'b0);
      if (vt[i].exp_busy) begin
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk($sformatf("vec%0d abort idle", i), 64'({busy, acc_clr}), 64'b01);
      end
      @(posedge clk); #1;
    end

    run_job("t1", 4, 2, 1'b0, 0, -1, -1);
    per = (ov_q.size() >= 2) ? ov_q[1] - ov_q[0] : -1;
    chk("t1 tile period", 64'(per), 64'd7);
    chk("t1 done count", 64'(done_cnt), 64'd1);
    run_job("t2", 3, 1, 1'b1, 0, -1, -1);
    run_job("t3", 4, 1, 1'b0, 1, -1, -1);
    run_job("t5 abort", 4, 2, 1'b0, 0, 12, -1);
    chk("t5 no out_valid after abort", 64'(ov_q.size()), 64'd1);
    run_job("t5 rerun", 4, 2, 1'b0, 0, -1, -1);
    run_job("t6", IFM_MAX, 1, 1'b0, 0, -1, 100);

    for (int r = 0; r < 14; r++) begin
      run_job($sformatf("rnd%0d", r), $urandom_range(1, 16), $urandom_range(1, 3),
              1'($urandom_range(0, 1)), $urandom_range(0, 2),
              ($urandom_range(0, 2) == 0) ? -2 : -1,
              ($urandom_range(0, 1) == 0) ? -2 : -1);
    end

    // Reset in the middle of a job returns everything to idle immediately.
    cfg_ifm_len   = AW'(4);
    cfg_num_tiles = TW'(2);
    cfg_bias_en   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ifm_valid = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid-op reset", raw_outs(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post reset idle", raw_outs(), '0);
    ifm_valid = 1'b0;
    @(posedge clk); #1;
    run_job("after reset", 2, 2, 1'b1, 0, -1, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
